// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_pkg
//  Description : Shared 8b/10b SerDes constants and types. The K28.5 comma
//                code groups for both running disparities, and the state
//                type used by the receive word aligner.
//  Revision    : 1.0  initial release
// ============================================================================
package serdes_pkg;

  // K28.5 comma in both running disparities, [9] = first bit on the line
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/serdes_comma_detect.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_comma_detect
//  Description : Combinational K28.5 detector on a 10-bit window. Reports
//                whether the window is a comma and, if so, whether it is the
//                RD+ form.
//  Revision    : 1.0  initial release
// ============================================================================
module serdes_comma_detect
  import serdes_pkg::*;
(
  input  logic [9:0] i_Win,
  output logic       o_Is_Comma,
  output logic       o_Is_Rdp
);

  logic w_Is_Rdn;

  // Exact match against either disparity form of K28.5
  always_comb begin
    w_Is_Rdn   = (i_Win == K28_5_RDN);
    o_Is_Rdp   = (i_Win == K28_5_RDP);
    o_Is_Comma = w_Is_Rdn | o_Is_Rdp;
  end

endmodule : serdes_comma_detect
`default_nettype wire

// File: rtl/serdes_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_word_aligner
//  Description : Receive word aligner. Shifts in one serial bit per enabled
//                clock, hunts for the K28.5 comma, confirms the 10-bit word
//                boundary over several commas and emits aligned code words
//                to the 8b/10b decoder. Falls back to hunting after repeated
//                off-boundary commas while locked.
//  Revision    : 1.0  initial release
// ============================================================================
module serdes_word_aligner
  import serdes_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_CNT  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic       i_Ser_Data,
  output logic [9:0] o_10B,
  output logic       o_10B_Valid,
  output logic       o_Comma,
  output logic       o_Locked,
  output logic       o_Align_Err
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W  = $clog2(ERR_CNT + 1);

  localparam logic [GOOD_W-1:0] c_GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] c_GOOD_MAX  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] c_GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0]  c_ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]  c_ERR_LAST  = ERR_W'(ERR_CNT - 1);
  localparam logic [3:0]        c_LAST_BIT  = 4'd9;

  logic [9:0]        r_Shift;
  logic [3:0]        r_Bit_Cnt;
  logic [GOOD_W-1:0] r_Good;
  logic [ERR_W-1:0]  r_Err;
  align_state_t      r_State;

  logic [9:0] w_Win;
  logic       w_Is_Comma;
  logic       w_Is_Rdp;
  logic       w_Boundary;
  logic       w_unused_rdp;

  // Window includes the bit arriving this cycle so a match is seen without
  // waiting a further clock
  assign w_Win        = {r_Shift[8:0], i_Ser_Data};
  assign w_Boundary   = (r_Bit_Cnt == c_LAST_BIT);
  // Disparity of the comma is not needed for alignment
  assign w_unused_rdp = w_Is_Rdp;

  serdes_comma_detect u_comma_detect (
    .i_Win      (w_Win),
    .o_Is_Comma (w_Is_Comma),
    .o_Is_Rdp   (w_Is_Rdp)
  );

  // Alignment state machine, bit counter, shift register and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Shift     <= '0;
      r_Bit_Cnt   <= '0;
      r_Good      <= '0;
      r_Err       <= '0;
      r_State     <= HUNT;
      o_10B       <= '0;
      o_10B_Valid <= 1'b0;
      o_Comma     <= 1'b0;
      o_Locked    <= 1'b0;
      o_Align_Err <= 1'b0;
    end else begin
      o_10B_Valid <= 1'b0;
      o_Align_Err <= 1'b0;
      if (i_En) begin
        r_Shift   <= w_Win;
        r_Bit_Cnt <= w_Boundary ? 4'd0 : r_Bit_Cnt + 4'd1;
        case (r_State)
          HUNT: begin
            if (w_Is_Comma) begin
              // Comma ends a word: the next bit starts the first aligned word
              o_10B       <= w_Win;
              o_10B_Valid <= 1'b1;
              o_Comma     <= 1'b1;
              r_Bit_Cnt   <= 4'd0;
              r_Good      <= c_GOOD_ONE;
              r_Err       <= '0;
              if (LOCK_CNT <= 1) begin
                r_State  <= LOCKED;
                o_Locked <= 1'b1;
              end else begin
                r_State <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (w_Boundary) begin
              o_10B       <= w_Win;
              o_10B_Valid <= 1'b1;
              o_Comma     <= w_Is_Comma;
              if (w_Is_Comma) begin
                if (r_Good >= c_GOOD_LAST) begin
                  r_Good   <= c_GOOD_MAX;
                  r_State  <= LOCKED;
                  o_Locked <= 1'b1;
                end else begin
                  r_Good <= r_Good + c_GOOD_ONE;
                end
              end
            end else if (w_Is_Comma) begin
              // Candidate phase contradicted before lock: quietly re-hunt
              r_Good  <= '0;
              r_State <= HUNT;
            end
          end
          LOCKED: begin
            if (w_Boundary) begin
              o_10B       <= w_Win;
              o_10B_Valid <= 1'b1;
              o_Comma     <= w_Is_Comma;
              if (w_Is_Comma) begin
                r_Err <= '0;
              end
            end else if (w_Is_Comma) begin
              if (r_Err >= c_ERR_LAST) begin
                r_Err       <= '0;
                r_Good      <= '0;
                r_State     <= HUNT;
                o_Locked    <= 1'b0;
                o_Align_Err <= 1'b1;
              end else begin
                r_Err <= r_Err + c_ERR_ONE;
              end
            end
          end
          default: begin
            r_State  <= HUNT;
            o_Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : serdes_word_aligner
`default_nettype wire

// File: tb/tb_serdes_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serdes_word_aligner
//  Description : Self-checking bench for serdes_word_aligner. Directed comma
//                sequences plus a randomized bit stream, compared cycle by
//                cycle against a bit-history reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serdes_word_aligner;
  import serdes_pkg::*;

  localparam int LOCK_CNT = 3;
  localparam int ERR_CNT  = 2;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;
  localparam logic [9:0] DATA_W = 10'b1010010110;

  logic r_Clk_Fast = 1'b0;
  logic r_Rst = 1'b0;
  logic r_En = 1'b0;
  logic r_Ser = 1'b0;
  logic [9:0] w_10B;
  logic w_Valid, w_Comma, w_Locked, w_Align_Err;

  int total = 0;
  int bad = 0;

  // reference model: raw bit history and absolute index of the word start
  bit   m_hist[$];
  int   m_idx, m_start, m_mode, m_good, m_err;
  logic [9:0] e_10B;
  logic e_valid, e_comma, e_locked, e_err;

  // observation logs
  logic [9:0] q_words[$];
  logic       q_comma[$];
  logic [9:0] t2_words[$];
  int n_err_pulse;
  bit valid_in_idle;

  always #5 r_Clk_Fast = ~r_Clk_Fast;

  serdes_word_aligner #(.LOCK_CNT(LOCK_CNT), .ERR_CNT(ERR_CNT)) dut (
    .i_Clk       (r_Clk_Fast),
    .i_Rst       (r_Rst),
    .i_En        (r_En),
    .i_Ser_Data  (r_Ser),
    .o_10B       (w_10B),
    .o_10B_Valid (w_Valid),
    .o_Comma     (w_Comma),
    .o_Locked    (w_Locked),
    .o_Align_Err (w_Align_Err)
  );

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < 10; i++) m_hist.push_back(1'b0);
    m_idx = 0; m_start = 0; m_mode = M_HUNT; m_good = 0; m_err = 0;
    e_10B = '0; e_valid = 0; e_comma = 0; e_locked = 0; e_err = 0;
  endtask

  task automatic emit(input logic [9:0] w, input logic c);
    e_10B = w; e_valid = 1'b1; e_comma = c;
  endtask

  task automatic model_step(input bit en, input bit b);
    logic [9:0] w;
    bit c, bnd;
    e_valid = 0;
    e_err   = 0;
    if (en) begin
      m_hist.push_back(b);
      void'(m_hist.pop_front());
      for (int i = 0; i < 10; i++) w[9-i] = m_hist[i];
      c   = (w == K28_5_RDN) || (w == K28_5_RDP);
      bnd = ((m_idx - m_start) % 10) == 9;
      if (m_mode == M_HUNT) begin
        if (c) begin
          emit(w, 1'b1);
          m_start = m_idx + 1;
          m_good = 1; m_err = 0;
          m_mode = (LOCK_CNT <= 1) ? M_LOCKED : M_VERIFY;
        end
      end else if (m_mode == M_VERIFY) begin
        if (bnd) begin
          emit(w, c);
          if (c) begin
            m_good = (m_good + 1 > LOCK_CNT) ? LOCK_CNT : m_good + 1;
            if (m_good >= LOCK_CNT) m_mode = M_LOCKED;
          end
        end else if (c) begin
          m_mode = M_HUNT; m_good = 0;
        end
      end else begin
        if (bnd) begin
          emit(w, c);
          if (c) m_err = 0;
        end else if (c) begin
          m_err++;
          if (m_err >= ERR_CNT) begin
            m_mode = M_HUNT; m_err = 0; m_good = 0; e_err = 1;
          end
        end
      end
      m_idx++;
      e_locked = (m_mode == M_LOCKED);
    end
  endtask

  task automatic step(input bit en, input bit b);
    @(negedge r_Clk_Fast);
    r_En  = en;
    r_Ser = b;
    model_step(en, b);
    @(posedge r_Clk_Fast);
    #1;
    check("valid", w_Valid, e_valid);
    check("align_err", w_Align_Err, e_err);
    check("locked", w_Locked, e_locked);
    check("word", w_10B, e_10B);
    check("comma", w_Comma, e_comma);
    if (w_Valid) begin
      q_words.push_back(w_10B);
      q_comma.push_back(w_Comma);
    end
    if (w_Valid && !en) valid_in_idle = 1;
    if (w_Align_Err) n_err_pulse++;
  endtask

  task automatic send_word(input logic [9:0] w, input int nbits, input bit gaps);
    for (int i = 9; i > 9 - nbits; i--) begin
      if (gaps) step(1'b0, 1'($urandom));
      step(1'b1, w[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge r_Clk_Fast);
    r_En = 0;
    r_Rst = 1;
    model_reset();
    #1;
    check("rst_word", w_10B, 10'd0);
    check("rst_flags", {w_Valid, w_Comma, w_Locked, w_Align_Err}, 10'd0);
    @(negedge r_Clk_Fast);
    r_Rst = 0;
    q_words.delete();
    q_comma.delete();
    n_err_pulse = 0;
    valid_in_idle = 0;
  endtask

  task automatic t2_stream(input bit gaps);
    send_word(10'b0000000101, 3, gaps);
    for (int k = 0; k < 3; k++) send_word(K28_5_RDN, 10, gaps);
    send_word(DATA_W, 10, gaps);
  endtask

  initial begin
    model_reset();

    // reset state and stream with junk prefix, three commas and a data word
    do_reset();
    t2_stream(1'b0);
    check("t2_nwords", 10'(q_words.size()), 10'd4);
    if (q_words.size() == 4) begin
      check("t2_first", q_words[0], K28_5_RDN);
      check("t2_first_comma", q_comma[0], 1'b1);
      check("t2_data", q_words[3], DATA_W);
      check("t2_data_comma", q_comma[3], 1'b0);
    end
    check("t2_locked", w_Locked, 1'b1);
    t2_words = q_words;

    // alternating disparity commas
    do_reset();
    send_word(K28_5_RDN, 10, 1'b0);
    check("t3_not_locked", w_Locked, 1'b0);
    send_word(K28_5_RDP, 10, 1'b0);
    check("t3_not_locked2", w_Locked, 1'b0);
    send_word(K28_5_RDN, 10, 1'b0);
    check("t3_locked", w_Locked, 1'b1);
    check("t3_nwords", 10'(q_words.size()), 10'd3);
    if (q_words.size() == 3) check("t3_rdp", q_words[1], K28_5_RDP);

    // slip one bit while locked, then relock on the new phase
    send_word(K28_5_RDN, 9, 1'b0);
    send_word(K28_5_RDN, 10, 1'b0);
    send_word(K28_5_RDN, 10, 1'b0);
    check("t4_err_pulses", 10'(n_err_pulse), 10'd1);
    check("t4_unlocked", w_Locked, 1'b0);
    for (int k = 0; k < 3; k++) send_word(K28_5_RDN, 10, 1'b0);
    check("t4_relocked", w_Locked, 1'b1);

    // asynchronous reset between clock edges while locked
    @(posedge r_Clk_Fast);
    #2;
    r_Rst = 1;
    model_reset();
    #1;
    check("t1_async_word", w_10B, 10'd0);
    check("t1_async_flags", {w_Valid, w_Comma, w_Locked, w_Align_Err}, 10'd0);
    @(posedge r_Clk_Fast);
    @(negedge r_Clk_Fast);
    r_Rst = 0;
    send_word(K28_5_RDP, 10, 1'b0);
    send_word(K28_5_RDP, 10, 1'b0);
    check("t1_needs_relock", w_Locked, 1'b0);
    send_word(K28_5_RDP, 10, 1'b0);
    check("t1_relocked", w_Locked, 1'b1);

    // same stream as the first test with idle cycles interleaved
    do_reset();
    t2_stream(1'b1);
    check("t5_nwords", 10'(q_words.size()), 10'(t2_words.size()));
    for (int i = 0; i < q_words.size() && i < t2_words.size(); i++)
      check("t5_word", q_words[i], t2_words[i]);
    check("t5_idle_valid", valid_in_idle, 1'b0);

    // randomized mix of commas, data, slips and stalls
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [9:0] rw;
      r  = $urandom_range(0, 9);
      rw = 10'($urandom);
      if (r < 5) begin
        rw = ($urandom_range(0, 1) == 1) ? K28_5_RDP : K28_5_RDN;
        send_word(rw, 10, ($urandom_range(0, 3) == 0));
      end else if (r < 8) begin
        send_word(rw, 10, ($urandom_range(0, 3) == 0));
      end else if (r == 8) begin
        send_word(K28_5_RDN, $urandom_range(1, 9), 1'b0);
      end else begin
        for (int i = 0; i < 6; i++) step(($urandom_range(0, 4) != 0), 1'($urandom));
      end
      if (n == 150) begin
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serdes_word_aligner
`default_nettype wire
